// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed, active-low 4-digit 7-segment scan back into digit values and dots.
// Optional macro SEG_DECODE_CHECK_EN enables the code_err/sel_err pattern and select checks.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] segment,
  input  logic [3:0] segsel,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] dot,
  output logic       frame_valid,
  output logic       code_err,
  output logic       sel_err
);

  localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);

  logic [7:0]       segMeta_q, segSync_q;
  logic [3:0]       selMeta_q, selSync_q, selPrev_q;
  logic [CW-1:0]    settleCnt_q, settleCnt_d;
  logic             dwellDone_q, dwellDone_d;
  logic [3:0]       mask_q, mask_d;
  logic [3:0][3:0]  shadowDig_q, shadowDig_d;
  logic [3:0]       shadowDot_q, shadowDot_d;
  logic [3:0][3:0]  digit_q;
  logic [3:0]       dot_q;
  logic             frameValid_q;

  logic       selChange;
  logic       captureEv;
  logic [3:0] selActive;
  logic       selOneHot;
  logic       frameDone;
  logic [3:0] decoded;

  function automatic logic [3:0] decodeSeg(input logic [6:0] pat);
    case (pat)
      7'h3F:   decodeSeg = 4'd0;
      7'h06:   decodeSeg = 4'd1;
      7'h5B:   decodeSeg = 4'd2;
      7'h4F:   decodeSeg = 4'd3;
      7'h66:   decodeSeg = 4'd4;
      7'h6D:   decodeSeg = 4'd5;
      7'h7D:   decodeSeg = 4'd6;
      7'h07:   decodeSeg = 4'd7;
      7'h7F:   decodeSeg = 4'd8;
      7'h6F:   decodeSeg = 4'd9;
      7'h00:   decodeSeg = 4'hA;
      default: decodeSeg = 4'hF;
    endcase
  endfunction

  // Two-flop synchronizers idle at all-ones so a reset looks like "nothing lit, no digit".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segMeta_q <= 8'hFF;
      segSync_q <= 8'hFF;
      selMeta_q <= 4'hF;
      selSync_q <= 4'hF;
      selPrev_q <= 4'hF;
    end else begin
      segMeta_q <= segment;
      segSync_q <= segMeta_q;
      selMeta_q <= segsel;
      selSync_q <= selMeta_q;
      selPrev_q <= selSync_q;
    end
  end

  assign selChange = (selSync_q != selPrev_q);
  assign captureEv = !selChange && (settleCnt_q == CNT_MAX) && !dwellDone_q;
  assign selActive = ~selSync_q;
  assign selOneHot = (selActive != 4'd0) && ((selActive & (selActive - 4'd1)) == 4'd0);
  assign frameDone = (mask_q == 4'hF);
  assign decoded   = decodeSeg(~segSync_q[6:0]);

  // The mask clears on the frame-update cycle, but a capture landing in that same cycle still sets its bit.
  always_comb begin
    settleCnt_d = settleCnt_q;
    dwellDone_d = dwellDone_q;
    mask_d      = frameDone ? 4'd0 : mask_q;
    shadowDig_d = shadowDig_q;
    shadowDot_d = shadowDot_q;
    if (selChange) begin
      settleCnt_d = '0;
      dwellDone_d = 1'b0;
    end else begin
      if (settleCnt_q != CNT_MAX) settleCnt_d = settleCnt_q + 1'b1;
      if (captureEv) dwellDone_d = 1'b1;
    end
    if (captureEv && selOneHot) begin
      for (int i = 0; i < 4; i++) begin
        if (selActive[i]) begin
          shadowDig_d[i] = decoded;
          shadowDot_d[i] = ~segSync_q[7];
          mask_d[i]      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settleCnt_q  <= '0;
      dwellDone_q  <= 1'b0;
      mask_q       <= 4'd0;
      shadowDig_q  <= {4{4'hA}};
      shadowDot_q  <= 4'd0;
      digit_q      <= {4{4'hA}};
      dot_q        <= 4'd0;
      frameValid_q <= 1'b0;
    end else begin
      settleCnt_q  <= settleCnt_d;
      dwellDone_q  <= dwellDone_d;
      mask_q       <= mask_d;
      shadowDig_q  <= shadowDig_d;
      shadowDot_q  <= shadowDot_d;
      frameValid_q <= frameDone;
      if (frameDone) begin
        digit_q <= shadowDig_q;
        dot_q   <= shadowDot_q;
      end
    end
  end

`ifdef SEG_DECODE_CHECK_EN
  logic codeErr_q, selErr_q;
  logic selIdle;

  assign selIdle = (selSync_q == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      codeErr_q <= 1'b0;
      selErr_q  <= 1'b0;
    end else begin
      codeErr_q <= captureEv && selOneHot && (decoded == 4'hF);
      selErr_q  <= captureEv && !selOneHot && !selIdle;
    end
  end

  assign code_err = codeErr_q;
  assign sel_err  = selErr_q;
`else
  assign code_err = 1'b0;
  assign sel_err  = 1'b0;
`endif

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign dot         = dot_q;
  assign frame_valid = frameValid_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed, table-driven bench for seg_scan_decoder: dwell-by-dwell scan vectors with
// expected frame counts, decoded outputs and error pulse counts, plus a mid-frame reset sequence.
module tb_seg_scan_decoder;

`ifdef SEG_DECODE_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] segment;
  logic [3:0] segsel;
  logic [3:0] digit0, digit1, digit2, digit3, dot;
  logic       frame_valid, code_err, sel_err;

  seg_scan_decoder #(.SETTLE_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .segment    (segment),
    .segsel     (segsel),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .dot        (dot),
    .frame_valid(frame_valid),
    .code_err   (code_err),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [7:0]  seg;
    int          cycles;
    int          expFrames;
    logic [15:0] expDig;
    logic [3:0]  expDot;
    int          expCodeErr;
    int          expSelErr;
  } vec_t;

  vec_t vecs[$];

  int assertCnt = 0;
  int failCnt = 0;
  int frameCnt = 0;
  int codeErrCnt = 0;
  int selErrCnt = 0;
  int stableViol = 0;
  logic [19:0] prevOut = {4'h0, 16'hAAAA};

  // Pulse counting and the "outputs only move with frame_valid" watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_valid) frameCnt++;
    if (code_err) codeErrCnt++;
    if (sel_err) selErrCnt++;
    if (rst_n && !frame_valid && ({dot, digit3, digit2, digit1, digit0} != prevOut))
      stableViol++;
    prevOut = {dot, digit3, digit2, digit1, digit0};
  end

  function automatic logic [7:0] enc(input int val, input bit dp);
    logic [6:0] p;
    case (val)
      0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
      4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;
      8: p = 7'h7F;  9: p = 7'h6F;  default: p = 7'h00;
    endcase
    return ~{dp, p};
  endfunction

  task automatic add(input logic [3:0] sel, input logic [7:0] seg, input int cycles,
                     input int frames, input logic [15:0] dig, input logic [3:0] dt,
                     input int ce, input int se);
    vec_t v;
    v.sel = sel; v.seg = seg; v.cycles = cycles; v.expFrames = frames;
    v.expDig = dig; v.expDot = dt; v.expCodeErr = ce; v.expSelErr = se;
    vecs.push_back(v);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] seg, input int cycles);
    segsel  = sel;
    segment = seg;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int frames, input logic [15:0] dig,
                             input logic [3:0] dt, input int ce, input int se);
    cmp({tag, ".frames"}, frameCnt, frames);
    cmp({tag, ".digits"}, {16'h0, digit3, digit2, digit1, digit0}, {16'h0, dig});
    cmp({tag, ".dot"}, {28'h0, dot}, {28'h0, dt});
    cmp({tag, ".code_err"}, codeErrCnt, ce);
    cmp({tag, ".sel_err"}, selErrCnt, se);
    cmp({tag, ".stable"}, stableViol, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    segsel  = 4'hF;
    segment = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    cmp("reset.digits", {16'h0, digit3, digit2, digit1, digit0}, 32'h0000AAAA);
    cmp("reset.dot", {28'h0, dot}, 32'h0);
    cmp("reset.frame_valid", {31'h0, frame_valid}, 32'h0);
    cmp("reset.code_err", {31'h0, code_err}, 32'h0);
    cmp("reset.sel_err", {31'h0, sel_err}, 32'h0);
    rst_n = 1'b1;
    applyStimulus(4'hF, 8'hFF, 30);
    checkOutput("idle", 0, 16'hAAAA, 4'h0, 0, 0);

    // Basic scan 5,3,dp+2,1
    add(4'b1110, enc(5, 0), 40, 0, 16'hAAAA, 4'b0000, 0, 0);
    add(4'b1101, enc(3, 0), 40, 0, 16'hAAAA, 4'b0000, 0, 0);
    add(4'b1011, enc(2, 1), 40, 0, 16'hAAAA, 4'b0000, 0, 0);
    add(4'b0111, enc(1, 0), 40, 1, 16'h1235, 4'b0100, 0, 0);
    // Short glitch to digit1, recapture of digit0, then an unrecognised pattern on digit1
    add(4'b1110, enc(9, 0), 40, 1, 16'h1235, 4'b0100, 0, 0);
    add(4'b1101, enc(7, 0),  3, 1, 16'h1235, 4'b0100, 0, 0);
    add(4'b1110, enc(9, 0), 40, 1, 16'h1235, 4'b0100, 0, 0);
    add(4'b1011, enc(4, 0), 40, 1, 16'h1235, 4'b0100, 0, 0);
    add(4'b0111, enc(0, 0), 40, 1, 16'h1235, 4'b0100, 0, 0);
    add(4'b1101, 8'hB6,     40, 2, 16'h04F9, 4'b0000, CHK, 0);
    // Invalid select, then idle select: neither may touch the mask
    add(4'b1100, enc(8, 0), 40, 2, 16'h04F9, 4'b0000, CHK, CHK);
    add(4'b1111, enc(8, 0), 40, 2, 16'h04F9, 4'b0000, CHK, CHK);
    add(4'b1011, enc(6, 0), 40, 2, 16'h04F9, 4'b0000, CHK, CHK);
    add(4'b0111, enc(7, 1), 40, 2, 16'h04F9, 4'b0000, CHK, CHK);
    add(4'b1110, enc(10, 0), 40, 2, 16'h04F9, 4'b0000, CHK, CHK);
    add(4'b1101, enc(8, 0), 40, 3, 16'h768A, 4'b1000, CHK, CHK);
    // Continuous 9,9,5,2 for three frames
    for (int g = 0; g < 3; g++) begin
      add(4'b1110, enc(9, 0), 40, 3 + g, (g == 0) ? 16'h768A : 16'h2599,
          (g == 0) ? 4'b1000 : 4'b0000, CHK, CHK);
      add(4'b1101, enc(9, 0), 40, 3 + g, (g == 0) ? 16'h768A : 16'h2599,
          (g == 0) ? 4'b1000 : 4'b0000, CHK, CHK);
      add(4'b1011, enc(5, 0), 40, 3 + g, (g == 0) ? 16'h768A : 16'h2599,
          (g == 0) ? 4'b1000 : 4'b0000, CHK, CHK);
      add(4'b0111, enc(2, 0), 40, 4 + g, 16'h2599, 4'b0000, CHK, CHK);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].sel, vecs[i].seg, vecs[i].cycles);
      checkOutput($sformatf("vec%0d", i), vecs[i].expFrames, vecs[i].expDig,
                  vecs[i].expDot, vecs[i].expCodeErr, vecs[i].expSelErr);
    end

    // Partial frame discarded by a mid-frame reset
    applyStimulus(4'b1110, enc(9, 0), 40);
    applyStimulus(4'b1101, enc(9, 0), 40);
    checkOutput("prerst", 6, 16'h2599, 4'b0000, CHK, CHK);
    rst_n  = 1'b0;
    segsel = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("inrst", 6, 16'hAAAA, 4'b0000, CHK, CHK);
    rst_n = 1'b1;
    applyStimulus(4'hF, 8'hFF, 5);
    applyStimulus(4'b1011, enc(3, 0), 40);
    checkOutput("post2", 6, 16'hAAAA, 4'b0000, CHK, CHK);
    applyStimulus(4'b0111, enc(4, 0), 40);
    checkOutput("post3", 6, 16'hAAAA, 4'b0000, CHK, CHK);
    applyStimulus(4'b1110, enc(1, 0), 40);
    checkOutput("post0", 6, 16'hAAAA, 4'b0000, CHK, CHK);
    applyStimulus(4'b1101, enc(2, 0), 40);
    checkOutput("post1", 7, 16'h4321, 4'b0000, CHK, CHK);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: cycles synchronized segsel must hold one value before its digit is sampled (minimum 2).
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 segment  input  8  multiplexed segment pins, active-low; bit0..bit6 = a..g, bit7 = dp.
REQ-005 segsel  input  4  digit select pins, active-low one-hot; bit n = digit n; 4'b1111 = no digit.
REQ-006 digit0..digit3  output  4 each  decoded digit values: 0-9, 4'hA = blank, 4'hF = unrecognised.
REQ-007 dot  output  4  decoded dp per digit, active-high.
REQ-008 frame_valid  output  1  one-cycle pulse when the digit/dot outputs have just been updated.
REQ-009 code_err  output  1  one-cycle pulse on capture of an unrecognised pattern.
REQ-010 sel_err  output  1  one-cycle pulse when a settled segsel value is neither one-hot-low nor 4'b1111.

Function
REQ-011 segment and segsel SHALL each pass through a 2-flop synchronizer; decoding SHALL use only synchronized values.
REQ-012 A settle counter SHALL clear on any change of synchronized segsel and otherwise increment, saturating at SETTLE_CYCLES-1.
REQ-013 The capture event SHALL occur once per dwell, on the first cycle the counter equals SETTLE_CYCLES-1; no further capture until segsel changes.
REQ-014 Pattern decode after inversion to active-high (a=bit0), bits[6:0]: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x7D->6, 0x07->7, 0x7F->8, 0x6F->9, 0x00->4'hA, any other->4'hF.
REQ-015 dp SHALL be decoded independently of bits[6:0]: dot = ~segment[7].
REQ-016 On capture with valid one-hot segsel, decoded value and dp SHALL be written to that digit's shadow register and its bit set in a 4-bit captured mask.
REQ-017 Recapture of an already-captured digit before frame completion SHALL overwrite its shadow entry; the mask is unchanged.
REQ-018 A settled segsel of 4'b1111 SHALL produce no capture, no error, and no mask change.
REQ-019 A settled invalid segsel (two or more bits low) SHALL produce no capture, leave the mask unchanged, and pulse sel_err once at the capture point.
REQ-020 The cycle after the capture that makes the mask 4'b1111: all four shadow entries SHALL copy to digit0..3/dot atomically, frame_valid SHALL pulse, and the mask SHALL clear.
REQ-021 Outputs SHALL change only on the frame_valid cycle; partial frames are never visible.
REQ-022 Latency: pin change to capture = 2 sync cycles + SETTLE_CYCLES; capture to output update = 1 cycle.
REQ-023 Capture and frame completion in the same dwell SHALL not conflict: a capture occurring on the output-update cycle SHALL set the mask bit in the freshly cleared mask.

Reset
REQ-024 On rst_n low: synchronizers SHALL reset to all-ones (off), the counter to 0, the mask to 0, shadows to 4'hA/dp 0, digit0..3 to 4'hA, dot to 0, and frame_valid/code_err/sel_err to 0.
REQ-025 Reset mid-frame SHALL discard partial captures; the first frame after reset SHALL require all four digits to be captured anew.

Configuration
REQ-026 Macro SEG_DECODE_CHECK_EN defined: code_err and sel_err SHALL behave per REQ-009/REQ-010/REQ-019.
REQ-027 Macro SEG_DECODE_CHECK_EN undefined: code_err and sel_err SHALL be constant 0 and the check logic SHALL be absent; decode values, including 4'hF, SHALL be unchanged.

Verification
REQ-028 Scan of digits 0..3 with patterns 5,3,dp+2,1 (dp on digit2), 40-cycle dwell each -> one frame_valid; digit0..3 = 5,3,2,1; dot = 4'b0100.
REQ-029 segsel glitch to another digit for 3 cycles (< SETTLE_CYCLES) -> no capture for the glitched digit; counter restarts; outputs unchanged.
REQ-030 Capture of pattern 0x49 on digit1 -> digit1 = 4'hF at frame end; code_err pulses once with macro defined, stays 0 without it.
REQ-031 segsel = 4'b1100 held 40 cycles -> sel_err pulses once, no mask change; 4'b1111 held -> no pulse, no capture.
REQ-032 Assert rst_n low after digits 0 and 1 are captured, then release and scan 4 digits -> exactly one frame_valid, after the fourth post-reset capture; outputs read 4'hA until then.
REQ-033 Continuous scan of 9,9,5,2 for 3 frames -> frame_valid every 4 dwells; outputs stable between pulses.
